// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the two-port LIFO stack arbiter.
package stack_arb_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 16;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time gets the grant. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       valid
);

  // Pick a one-hot winner; ties go to the non-last-granted side.
  always_comb begin
    valid = |req;
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin controller sharing one LIFO stack macro between two clients.
// One stack command per transaction; occupancy is tracked locally and
// cross-checked against the stack's EMPTY/FULL flags.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             rw0,
  input  logic             rw1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             stk_en,
  output logic             stk_rw,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_empty,
  input  logic             stk_full,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             sync_err
);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             last_grant_q, last_grant_d;
  logic             sync_err_q, sync_err_d;
  logic             win_q, win_d;
  logic             op_q, op_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             err0_q, err0_d, err1_q, err1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             stk_en_q, stk_en_d;
  logic             stk_rw_q, stk_rw_d;
  logic [WIDTH-1:0] stk_din_q, stk_din_d;
  logic             busy_q, busy_d;

  logic [1:0]       arb_grant;
  logic             arb_valid;
  logic             sel_rw;
  logic [WIDTH-1:0] sel_data;
  logic             sel_reject;
  logic [WIDTH-1:0] pop_word;

  rr_arb2 u_arb (
    .req        ({req1, req0}),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign sel_rw     = (arb_grant[0] & rw0) | (arb_grant[1] & rw1);
  assign sel_data   = ({WIDTH{arb_grant[0]}} & wdata0) | ({WIDTH{arb_grant[1]}} & wdata1);
  assign sel_reject = (sel_rw == OP_PUSH) ? (count_q == CW'(DEPTH)) : (count_q == CW'(0));
  assign pop_word   = (op_q == OP_POP) ? stk_dout : '0;

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    // NOTE: every *_d gets a default before the case so no path infers a latch.
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    sync_err_d   = sync_err_q;
    win_d        = win_q;
    op_d         = op_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = '0;
    rdata1_d     = '0;
    stk_en_d     = 1'b0;
    stk_rw_d     = stk_rw_q;
    stk_din_d    = stk_din_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_d = arb_grant[1];
          op_d  = sel_rw;
          if (sel_reject) begin
            // Push on full / pop on empty: answer at once, never touch the stack.
            state_d = DONE;
            ack0_d  = arb_grant[0];
            ack1_d  = arb_grant[1];
            err0_d  = arb_grant[0];
            err1_d  = arb_grant[1];
          end else begin
            state_d   = ISSUE;
            stk_en_d  = 1'b1;
            stk_rw_d  = sel_rw;
            stk_din_d = sel_data;
          end
        end
      end
      ISSUE: begin
        count_d = (op_q == OP_PUSH) ? count_q + CW'(1) : count_q - CW'(1);
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if ((stk_empty != (count_q == CW'(0))) || (stk_full != (count_q == CW'(DEPTH)))) begin
          sync_err_d = 1'b1;
        end
        state_d = DONE;
        ack0_d  = ~win_q;
        ack1_d  = win_q;
        if (win_q) rdata1_d = pop_word;
        else       rdata0_d = pop_word;
      end
      DONE: begin
        last_grant_d = win_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; an asynchronous reset aborts any transaction.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      sync_err_q   <= 1'b0;
      win_q        <= 1'b0;
      op_q         <= OP_PUSH;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      stk_en_q     <= 1'b0;
      stk_rw_q     <= 1'b0;
      stk_din_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of the others.
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      sync_err_q   <= sync_err_d;
      win_q        <= win_d;
      op_q         <= op_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      stk_en_q     <= stk_en_d;
      stk_rw_q     <= stk_rw_d;
      stk_din_q    <= stk_din_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign stk_en   = stk_en_q;
  assign stk_rw   = stk_rw_q;
  assign stk_din  = stk_din_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign sync_err = sync_err_q;

endmodule
